// File: rtl/fetch_align_rvc.sv
// fetch_align_rvc
//
// Halfword-granular fetch alignment queue sitting between the I-cache fetch
// stage and decode. Fetch packets of FETCH_BYTES bytes are split into
// halfwords and pushed into a circular queue, each halfword tagged with its
// own pc. The head of the queue is decoded every cycle. A 32-bit instruction
// is built from two consecutive halfwords and may straddle two packets. A
// 16-bit RV32C instruction is expanded to its 32-bit equivalent. One
// instruction per cycle is handed to decode through a valid/ready handshake.
//
// Parameters
//   FETCH_BYTES  bytes per fetch packet (4, 8 or 16)
//   HW_ENTRIES   halfword queue depth (power of 2, at least FETCH_BYTES)
//
// Ports
//   clk           clock
//   reset         asynchronous active-high reset
//   flush         discard every queued halfword (redirect)
//   fetch_valid   fetch packet present
//   fetch_ready   a whole packet fits in the queue this cycle
//   fetch_pc      byte address of the first valid halfword (2-byte aligned)
//   fetch_data    packet; halfword i sits at bits [16i+15:16i]
//   insn_valid    insn / insn_pc / insn_is_rvc / insn_illegal are valid
//   insn_ready    decode consumes the instruction this cycle
//   insn          32-bit instruction (expanded if it was compressed)
//   insn_pc       pc of insn
//   insn_is_rvc   insn came from a 16-bit encoding
//   insn_illegal  16-bit encoding is illegal or unsupported (insn is 0)

`ifndef M_WIDTH
`define M_WIDTH 32
`endif

module fetch_align_rvc #(
    parameter int FETCH_BYTES = 8,
    parameter int HW_ENTRIES  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [`M_WIDTH-1:0]      fetch_pc,
    input  logic [FETCH_BYTES*8-1:0] fetch_data,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    output logic [31:0]              insn,
    output logic [`M_WIDTH-1:0]      insn_pc,
    output logic                     insn_is_rvc,
    output logic                     insn_illegal
);

    localparam int HPF   = FETCH_BYTES / 2;
    localparam int FB_LG = $clog2(FETCH_BYTES);
    localparam int PTR_W = $clog2(HW_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam int MW    = `M_WIDTH;

    // Returns {illegal, insn}. Register fields x8..x15 are encoded in three
    // bits in the compressed forms. Every immediate is rebuilt in the bit
    // order of the 32-bit format, with sign extension where the ISA calls
    // for it. When the encoding is illegal the instruction field is forced
    // to zero.
    function automatic logic [32:0] expand_rvc(input logic [15:0] c);
        logic [31:0] x;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rdp;
        logic [4:0]  rs1p;
        logic [11:0] imm6_sx;
        logic [11:0] lw_off;
        logic [11:0] j_off;
        logic [20:0] j_imm;
        logic [12:0] b_imm;
        logic [11:0] a16_imm;
        logic [19:0] lui_imm;
        logic [11:0] a4spn_imm;
        logic [11:0] lwsp_off;
        logic [11:0] swsp_off;
        logic [9:0]  jal_fld;

        x         = 32'h0;
        ill       = 1'b0;
        rd        = c[11:7];
        rs2       = c[6:2];
        rdp       = {2'b01, c[4:2]};
        rs1p      = {2'b01, c[9:7]};
        imm6_sx   = {{6{c[12]}}, c[12], c[6:2]};
        lw_off    = {5'b0, c[5], c[12:10], c[6], 2'b00};
        j_off     = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        j_imm     = {{9{c[12]}}, j_off};
        b_imm     = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        a16_imm   = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
        lui_imm   = {{14{c[12]}}, c[12], c[6:2]};
        a4spn_imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
        lwsp_off  = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
        swsp_off  = {4'b0, c[8:7], c[12:9], 2'b00};
        jal_fld   = j_imm[10:1];

        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        // C.ADDI4SPN; an all-zero immediate also covers the
                        // all-zero halfword.
                        ill = (c[12:5] == 8'h00);
                        x   = {a4spn_imm, 5'd2, 3'b000, rdp, 7'b0010011};
                    end
                    3'b010: x = {lw_off, rs1p, 3'b010, rdp, 7'b0000011};
                    3'b110: x = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], 7'b0100011};
                    default: ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: x = {imm6_sx, rd, 3'b000, rd, 7'b0010011};
                    3'b001: x = {j_imm[20], jal_fld, j_imm[11], j_imm[19:12], 5'd1, 7'b1101111};
                    3'b010: x = {imm6_sx, 5'd0, 3'b000, rd, 7'b0010011};
                    3'b011: begin
                        if (rd == 5'd2) begin
                            ill = (a16_imm == 12'h000);
                            x   = {a16_imm, 5'd2, 3'b000, 5'd2, 7'b0010011};
                        end else begin
                            ill = ({c[12], c[6:2]} == 6'h00);
                            x   = {lui_imm, rd, 7'b0110111};
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                ill = c[12];
                                x   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                            end
                            2'b01: begin
                                ill = c[12];
                                x   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
                            end
                            2'b10: x = {imm6_sx, rs1p, 3'b111, rs1p, 7'b0010011};
                            default: begin
                                // c[12]=1 holds the RV64-only word forms.
                                if (c[12]) begin
                                    ill = 1'b1;
                                end else begin
                                    case (c[6:5])
                                        2'b00: x = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                                        2'b01: x = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                                        2'b10: x = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                                        default: x = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                                    endcase
                                end
                            end
                        endcase
                    end
                    3'b101: x = {j_imm[20], jal_fld, j_imm[11], j_imm[19:12], 5'd0, 7'b1101111};
                    3'b110: x = {b_imm[12], b_imm[10:5], 5'd0, rs1p, 3'b000, b_imm[4:1], b_imm[11], 7'b1100011};
                    default: x = {b_imm[12], b_imm[10:5], 5'd0, rs1p, 3'b001, b_imm[4:1], b_imm[11], 7'b1100011};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        ill = c[12];
                        x   = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
                    end
                    3'b010: begin
                        ill = (rd == 5'd0);
                        x   = {lwsp_off, 5'd2, 3'b010, rd, 7'b0000011};
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                ill = (rd == 5'd0);
                                x   = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};
                            end else begin
                                x = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                            end
                        end else begin
                            if (rs2 == 5'd0 && rd == 5'd0) begin
                                x = 32'h00100073;
                            end else if (rs2 == 5'd0) begin
                                x = {12'h000, rd, 3'b000, 5'd1, 7'b1100111};
                            end else begin
                                x = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
                            end
                        end
                    end
                    3'b110: x = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], 7'b0100011};
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            x = 32'h0;
        end
        return {ill, x};
    endfunction

    logic [15:0]      hw_q [HW_ENTRIES];
    logic [15:0]      hw_d [HW_ENTRIES];
    logic [MW-1:0]    pc_q [HW_ENTRIES];
    logic [MW-1:0]    pc_d [HW_ENTRIES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [FB_LG-2:0] off;
    logic [MW-1:0]    base_pc;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    logic [15:0]      h0;
    logic [15:0]      h1;
    logic             len32;
    logic             head_valid;
    logic [32:0]      expanded;
    logic             unused_pc_bit;

    assign unused_pc_bit = fetch_pc[0];

    // Only the registered count is used here. A pop in the same cycle does
    // not free space for a push, so the ready path stays short.
    assign fetch_ready = ((CNT_W'(HW_ENTRIES) - count_q) >= CNT_W'(HPF));

    // Head decode. A 32-bit instruction takes the next entry as its upper
    // half with no pc check. The frontend guarantees sequential pcs across
    // packets.
    always_comb begin
        h0         = hw_q[head_q];
        h1         = hw_q[head_q + PTR_W'(1)];
        len32      = (h0[1:0] == 2'b11);
        head_valid = len32 ? (count_q >= CNT_W'(2)) : (count_q >= CNT_W'(1));
        expanded   = expand_rvc(h0);

        insn_valid   = head_valid;
        insn         = 32'h0;
        insn_pc      = '0;
        insn_is_rvc  = 1'b0;
        insn_illegal = 1'b0;
        if (head_valid) begin
            insn         = len32 ? {h1, h0} : expanded[31:0];
            insn_pc      = pc_q[head_q];
            insn_is_rvc  = !len32;
            insn_illegal = !len32 && expanded[32];
        end
    end

    // Queue update. flush wins over both push and pop. Halfwords below the
    // entry offset of a packet belong to an earlier pc and are dropped. The
    // rest are written in order starting at the tail.
    always_comb begin
        hw_d    = hw_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        off     = fetch_pc[FB_LG-1:1];
        base_pc = {fetch_pc[MW-1:FB_LG], {FB_LG{1'b0}}};
        push    = fetch_valid && fetch_ready && !flush;
        pop     = head_valid && insn_ready && !flush;
        push_n  = push ? (CNT_W'(HPF) - CNT_W'(off)) : '0;
        pop_n   = pop ? (len32 ? CNT_W'(2) : CNT_W'(1)) : '0;

        for (int j = 0; j < HPF; j++) begin
            if (push && (j >= int'(off))) begin
                hw_d[tail_q + PTR_W'(j - int'(off))] = fetch_data[16*j +: 16];
                pc_d[tail_q + PTR_W'(j - int'(off))] = base_pc + MW'(2 * j);
            end
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_q + push_n - pop_n;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset. Entries are qualified by count and the outputs
    // are gated by insn_valid.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
        pc_q <= pc_d;
    end

endmodule
